// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with saturation at 9999.
// Optional leading-zero blanking of the upper three digits: define BIN2BCD_BLANK_EN.

module bin2bcd_nib (
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bin,
  output logic             out_valid,
  output logic [15:0]      bcd,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);
  // Only reachable when WIDTH can represent values above 9999.
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(9999);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [15:0]       scr_q, scr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovfp_q, ovfp_d;
  logic [15:0]       bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic              ov_q, ov_d;

  logic [15:0]       adj;
  logic [15:0]       raw, fin;
  logic [WIDTH+15:0] sh;
  logic              big;

  for (genvar n = 0; n < 4; n++) begin : g_nib
    bin2bcd_nib u_nib (.d_i(scr_q[4*n+:4]), .q_o(adj[4*n+:4]));
  end

  assign sh  = {adj, bin_q} << 1;
  assign raw = sh[WIDTH+15:WIDTH];
  assign big = 32'(in_bin) > 32'd9999;

`ifdef BIN2BCD_BLANK_EN
  always_comb begin
    fin = raw;
    if (raw[15:12] == 4'd0) begin
      fin[15:12] = 4'hF;
      if (raw[11:8] == 4'd0) begin
        fin[11:8] = 4'hF;
        if (raw[7:4] == 4'd0) fin[7:4] = 4'hF;
      end
    end
  end
`else
  assign fin = raw;
`endif

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    ovfp_d  = ovfp_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d   = big ? MAXV : in_bin;
          scr_d   = 16'h0000;
          ovfp_d  = big;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = raw;
        bin_d = sh[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = fin;
          ovf_d   = ovfp_q;
          ov_d    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      scr_q   <= 16'h0000;
      cnt_q   <= '0;
      ovfp_q  <= 1'b0;
      bcd_q   <= 16'h0000;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      ovfp_q  <= ovfp_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = ov_q;
  assign bcd       = bcd_q;
  assign overflow  = ovf_q;
endmodule
